// File: rtl/ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings and master FSM state type.
package ahb_lite_master_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001
  } hburst_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite command-driven master: one command = 1..16 byte beats, read or write.
// Define AHBM_BURST_EN for INCR/SEQ bursts; otherwise each beat is a SINGLE NONSEQ with an IDLE gap.
module ahb_lite_master
  import ahb_lite_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [1:0]            HTRANS,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA
);

  state_t               state;
  logic [LEN_WIDTH-1:0] beats_left;
  logic                 addr_phase;
  logic                 data_phase;

  always_comb begin
    addr_phase = (state == ST_ADDR) || (state == ST_BURST);
    data_phase = (state == ST_BURST) || (state == ST_LAST);
  end

  // The pop must coincide with the edge that completes the address phase, so it follows HREADY directly.
  always_comb begin
    wdata_pop = addr_phase && HWRITE && HREADY;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      beats_left  <= '0;
      cmd_ready   <= 1'b1;
      HTRANS      <= HTRANS_IDLE;
      HADDR       <= '0;
      HWRITE      <= 1'b0;
      HSIZE       <= '0;
      HBURST      <= '0;
      HWDATA      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      if (data_phase && HREADY && !HRESP && !HWRITE) begin
        rdata       <= HRDATA;
        rdata_valid <= 1'b1;
      end
      if (wdata_pop) begin
        HWDATA <= wdata;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state      <= ST_ADDR;
            cmd_ready  <= 1'b0;
            err        <= 1'b0;
            beats_left <= cmd_len;
            HTRANS     <= HTRANS_NONSEQ;
            HADDR      <= cmd_addr;
            HWRITE     <= cmd_write;
            HSIZE      <= HSIZE_BYTE;
`ifdef AHBM_BURST_EN
            HBURST     <= (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
`else
            HBURST     <= HBURST_SINGLE;
`endif
          end
        end
        ST_ADDR, ST_BURST: begin
          if (data_phase && HRESP && !HREADY) begin
            state  <= ST_ERR1;
            HTRANS <= HTRANS_IDLE;
          end else if (HREADY) begin
`ifdef AHBM_BURST_EN
            if (beats_left != '0) begin
              state      <= ST_BURST;
              HTRANS     <= HTRANS_SEQ;
              HADDR      <= HADDR + ADDR_WIDTH'(1);
              beats_left <= beats_left - LEN_WIDTH'(1);
            end else begin
              state  <= ST_LAST;
              HTRANS <= HTRANS_IDLE;
            end
`else
            state  <= ST_LAST;
            HTRANS <= HTRANS_IDLE;
`endif
          end
        end
        ST_LAST: begin
          if (HRESP && !HREADY) begin
            state  <= ST_ERR1;
            HTRANS <= HTRANS_IDLE;
          end else if (HREADY) begin
            // Only single-beat mode reaches here with beats left: the IDLE gap ends and the next NONSEQ starts.
            if (beats_left == '0) begin
              state     <= ST_IDLE;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
            end else begin
              state      <= ST_ADDR;
              HTRANS     <= HTRANS_NONSEQ;
              HADDR      <= HADDR + ADDR_WIDTH'(1);
              beats_left <= beats_left - LEN_WIDTH'(1);
            end
          end
        end
        ST_ERR1: begin
          if (HRESP && HREADY) begin
            state <= ST_ERR2;
            err   <= 1'b1;
            done  <= 1'b1;
          end
        end
        ST_ERR2: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          HTRANS    <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Cycle-by-cycle vector bench for ahb_lite_master; expectations follow AHBM_BURST_EN.
module tb_ahb_lite_master;

  localparam int I  = 0;
  localparam int N  = 2;
  localparam int S  = 3;
  localparam int SG = 0;
  localparam int IN = 1;
  localparam int D  = -1;

  logic       HCLK;
  logic       HRESETn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic [7:0] wdata;
  logic       wdata_pop;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       done;
  logic       err;
  logic [3:0] HADDR;
  logic       HWRITE;
  logic [2:0] HSIZE;
  logic [2:0] HBURST;
  logic [1:0] HTRANS;
  logic [7:0] HWDATA;
  logic       HREADY;
  logic       HRESP;
  logic [7:0] HRDATA;

  ahb_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata(wdata), .wdata_pop(wdata_pop),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Inputs for one cycle, then the outputs expected in that same cycle (D = don't care).
  typedef struct {
    logic       rstn, cv, cw;
    logic [3:0] ca, cl;
    logic [7:0] wd;
    logic       hr, hs;
    logic [7:0] hrd;
    int         t, a, b, hw, hwd, pop, rv, rd, dn, er, rdy;
  } vec_t;

  vec_t s [32];
  int   n;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input int i, input string f, input int act, input int exp);
    if (exp >= 0) begin
      checks++;
      if (act != exp) begin
        errors++;
        $display("FAIL %s[%0d] %s: got %0h want %0h", nm, i, f, act, exp);
      end
    end
  endtask

  task automatic step(input vec_t v, input string nm, input int i);
    HRESETn   = v.rstn;
    cmd_valid = v.cv;
    cmd_write = v.cw;
    cmd_addr  = v.ca;
    cmd_len   = v.cl;
    wdata     = v.wd;
    HREADY    = v.hr;
    HRESP     = v.hs;
    HRDATA    = v.hrd;
    @(negedge HCLK);
    chk(nm, i, "htrans", int'(HTRANS), v.t);
    chk(nm, i, "haddr", int'(HADDR), v.a);
    chk(nm, i, "hburst", int'(HBURST), v.b);
    chk(nm, i, "hwrite", int'(HWRITE), v.hw);
    chk(nm, i, "hwdata", int'(HWDATA), v.hwd);
    chk(nm, i, "wdata_pop", int'(wdata_pop), v.pop);
    chk(nm, i, "rdata_valid", int'(rdata_valid), v.rv);
    chk(nm, i, "rdata", int'(rdata), v.rd);
    chk(nm, i, "done", int'(done), v.dn);
    chk(nm, i, "err", int'(err), v.er);
    chk(nm, i, "cmd_ready", int'(cmd_ready), v.rdy);
    chk(nm, i, "hsize", int'(HSIZE), 0);
    @(posedge HCLK);
    #1;
  endtask

  task automatic run(input string nm);
    for (int i = 0; i < n; i++) step(s[i], nm, i);
  endtask

  initial begin
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (2) @(posedge HCLK);
    #1;

    // rstn,cv,cw,ca,cl,wd,hr,hs,hrd | htrans,haddr,hburst,hwrite,hwdata,pop,rvalid,rdata,done,err,ready
    s[0]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,0,SG,0,0,0,0,0,0,0,1};
    s[1]  = '{1,1,1,4'h3,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    s[2]  = '{1,0,0,4'h0,0,8'hA5,1,0,8'h00, N,3,SG,1,D,1,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,8'hA5,0,0,D,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,1,0,1};
    s[5]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    s[6]  = '{1,1,0,4'hF,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    s[7]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,15,SG,0,D,0,0,D,0,0,0};
    s[8]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h5A, I,D,D,D,D,0,0,D,0,0,0};
    s[9]  = '{1,1,0,4'h7,0,8'h00,1,0,8'h00, I,D,D,D,D,0,1,8'h5A,1,0,1};
    s[10] = '{1,0,0,4'h0,0,8'h00,0,0,8'h00, N,7,SG,0,D,0,0,D,0,0,0};
    s[11] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,7,SG,0,D,0,0,D,0,0,0};
    s[12] = '{1,0,0,4'h0,0,8'h00,0,0,8'hEE, I,D,D,D,D,0,0,D,0,0,0};
    s[13] = '{1,0,0,4'h0,0,8'h00,1,0,8'hC3, I,D,D,D,D,0,0,D,0,0,0};
    s[14] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,1,8'hC3,1,0,1};
    s[15] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    s[16] = '{1,1,1,4'h2,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    s[17] = '{1,0,0,4'h0,0,8'h66,1,0,8'h00, N,2,SG,1,D,1,0,D,0,0,0};
    s[18] = '{1,0,0,4'h0,0,8'h00,0,1,8'h00, I,D,D,D,8'h66,0,0,D,0,0,0};
    s[19] = '{1,0,0,4'h0,0,8'h00,1,1,8'h00, I,D,D,D,8'h66,0,0,D,0,0,0};
    s[20] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,1,1,0};
    s[21] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,1,1};
    s[22] = '{1,1,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,1,1};
    s[23] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,0,SG,0,D,0,0,D,0,0,0};
    s[24] = '{1,0,0,4'h0,0,8'h00,1,0,8'h99, I,D,D,D,D,0,0,D,0,0,0};
    s[25] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,1,8'h99,1,0,1};
    n = 26;
    run("single");

    // Read len=3 from 0xE: address wraps 0xF -> 0x0, four beats in order.
    s[0]  = '{1,1,0,4'hE,3,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
`ifdef AHBM_BURST_EN
    s[1]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,14,IN,0,D,0,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h10, S,15,IN,0,D,0,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h11, S,0,IN,0,D,0,1,8'h10,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h12, S,1,IN,0,D,0,1,8'h11,0,0,0};
    s[5]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h13, I,D,D,D,D,0,1,8'h12,0,0,0};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,1,8'h13,1,0,1};
    s[7]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    n = 8;
`else
    s[1]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,14,SG,0,D,0,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h10, I,D,D,D,D,0,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,15,SG,0,D,0,1,8'h10,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h11, I,D,D,D,D,0,0,D,0,0,0};
    s[5]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,0,SG,0,D,0,1,8'h11,0,0,0};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h12, I,D,D,D,D,0,0,D,0,0,0};
    s[7]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,1,SG,0,D,0,1,8'h12,0,0,0};
    s[8]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h13, I,D,D,D,D,0,0,D,0,0,0};
    s[9]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,1,8'h13,1,0,1};
    s[10] = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    n = 11;
`endif
    run("rdwrap");

    // Write len=1 to 0x5 with two wait states on the first data phase.
    s[0]  = '{1,1,1,4'h5,1,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
`ifdef AHBM_BURST_EN
    s[1]  = '{1,0,0,4'h0,0,8'h31,1,0,8'h00, N,5,IN,1,D,1,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'h32,0,0,8'h00, S,6,IN,1,8'h31,0,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'h32,0,0,8'h00, S,6,IN,1,8'h31,0,0,D,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h32,1,0,8'h00, S,6,IN,1,8'h31,1,0,D,0,0,0};
    s[5]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,8'h32,0,0,D,0,0,0};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,1,0,1};
    n = 7;
`else
    s[1]  = '{1,0,0,4'h0,0,8'h31,1,0,8'h00, N,5,SG,1,D,1,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'h32,0,0,8'h00, I,D,D,D,8'h31,0,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'h32,0,0,8'h00, I,D,D,D,8'h31,0,0,D,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h32,1,0,8'h00, I,D,D,D,8'h31,0,0,D,0,0,0};
    s[5]  = '{1,0,0,4'h0,0,8'h32,1,0,8'h00, N,6,SG,1,8'h31,1,0,D,0,0,0};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,8'h32,0,0,D,0,0,0};
    s[7]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,1,0,1};
    n = 8;
`endif
    run("wrwait");

    // Read len=3 from 0x8, slave errors on beat 1.
    s[0]  = '{1,1,0,4'h8,3,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
`ifdef AHBM_BURST_EN
    s[1]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,8,IN,0,D,0,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h40, S,9,IN,0,D,0,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'h00,0,1,8'h00, S,10,IN,0,D,0,1,8'h40,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h00,1,1,8'h00, I,D,D,D,D,0,0,D,0,0,0};
    s[5]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,1,1,0};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,1,1};
    s[7]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,1,1};
    n = 8;
`else
    s[1]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,8,SG,0,D,0,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h40, I,D,D,D,D,0,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, N,9,SG,0,D,0,1,8'h40,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h00,0,1,8'h00, I,D,D,D,D,0,0,D,0,0,0};
    s[5]  = '{1,0,0,4'h0,0,8'h00,1,1,8'h00, I,D,D,D,D,0,0,D,0,0,0};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,1,1,0};
    s[7]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,1,1};
    s[8]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,1,1};
    n = 9;
`endif
    run("rderr");

    // Write len=3 from 0x0, reset asserted while beat 2 address is on the bus.
    s[0]  = '{1,1,1,4'h0,3,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,1,1};
`ifdef AHBM_BURST_EN
    s[1]  = '{1,0,0,4'h0,0,8'hB0,1,0,8'h00, N,0,IN,1,D,1,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'hB1,1,0,8'h00, S,1,IN,1,8'hB0,1,0,D,0,0,0};
    s[3]  = '{0,0,0,4'h0,0,8'hB2,0,0,8'h00, S,2,IN,1,8'hB1,0,0,D,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,0,SG,0,0,0,0,0,0,0,1};
    s[5]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    n = 7;
`else
    s[1]  = '{1,0,0,4'h0,0,8'hB0,1,0,8'h00, N,0,SG,1,D,1,0,D,0,0,0};
    s[2]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,8'hB0,0,0,D,0,0,0};
    s[3]  = '{1,0,0,4'h0,0,8'hB1,1,0,8'h00, N,1,SG,1,8'hB0,1,0,D,0,0,0};
    s[4]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,8'hB1,0,0,D,0,0,0};
    s[5]  = '{0,0,0,4'h0,0,8'hB2,0,0,8'h00, N,2,SG,1,8'hB1,0,0,D,0,0,0};
    s[6]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,0,SG,0,0,0,0,0,0,0,1};
    s[7]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    s[8]  = '{1,0,0,4'h0,0,8'h00,1,0,8'h00, I,D,D,D,D,0,0,D,0,0,1};
    n = 9;
`endif
    run("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 4, address bus width; DATA_WIDTH, 8, data bus width; LEN_WIDTH, 4, beat-count field width.
REQ-002 One clock; reset is synchronous and active-low.
REQ-003 HCLK  in  1  rising-edge clock for all state.
REQ-004 HRESETn  in  1  synchronous active-low reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_write  in  1  1 = write, 0 = read.
REQ-008 cmd_addr  in  ADDR_WIDTH  start address.
REQ-009 cmd_len  in  LEN_WIDTH  beats minus 1 (0 = 1 beat, 15 = 16 beats).
REQ-010 wdata  in  DATA_WIDTH  write data for the next beat, valid whenever wdata_pop is high.
REQ-011 wdata_pop  out  1  pulse: wdata consumed this edge.
REQ-012 rdata  out  DATA_WIDTH  read beat data.
REQ-013 rdata_valid  out  1  one-cycle pulse per completed read beat.
REQ-014 done  out  1  one-cycle pulse when a command finishes (ok or error).
REQ-015 err  out  1  sticky error flag, cleared on next command accept.
REQ-016 HADDR  out  ADDR_WIDTH; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HTRANS  out  2; HWDATA  out  DATA_WIDTH.
REQ-017 HREADY  in  1; HRESP  in  1; HRDATA  in  DATA_WIDTH.

Function
REQ-018 States: IDLE, ADDR, BURST, LAST, ERR1, ERR2.
REQ-019 IDLE: cmd_ready=1, HTRANS=IDLE; on accept latch cmd fields, clear err, go ADDR.
REQ-020 ADDR: drive HTRANS=NONSEQ, HADDR=start, HSIZE=3'b000, HBURST=SINGLE if len=0 else INCR; hold all address-phase outputs while HREADY=0.
REQ-021 Address phase completes on the edge where HREADY=1; for writes, wdata_pop=1 in that cycle and HWDATA is registered from wdata at that edge.
REQ-022 BURST: beats after the first are driven with HTRANS=SEQ, HADDR = previous + 1 modulo 2^ADDR_WIDTH (0xF wraps to 0x0); address of beat n overlaps data phase of beat n-1.
REQ-023 After the last address phase completes go LAST with HTRANS=IDLE; on HREADY=1 the final data phase completes, done=1, return IDLE.
REQ-024 Read beat: on the edge a read data phase completes with HREADY=1 and HRESP=0, rdata=HRDATA and rdata_valid=1 the following cycle.
REQ-025 HWDATA held stable for the entire data phase, including wait states.
REQ-026 HRESP=1 with HREADY=0 (first error cycle) in any data phase: go ERR1; master drives HTRANS=IDLE in that next cycle, cancelling any pending address phase; no further wdata_pop or rdata_valid.
REQ-027 ERR1 -> ERR2 when HRESP=1 and HREADY=1; ERR2 asserts err=1 and done=1, then IDLE.
REQ-028 cmd_ready=0 in every state except IDLE; back-to-back commands therefore have at least one IDLE cycle between.
REQ-029 Beat counter counts address phases issued; cmd_len=15 issues exactly 16 beats.

Reset
REQ-030 On HCLK edge with HRESETn=0: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, rdata=0, rdata_valid=0, wdata_pop=0, done=0, err=0, cmd_ready=1 after release.
REQ-031 Reset mid-burst abandons the transfer with no done pulse.

Configuration
REQ-032 Macro AHBM_BURST_EN defined: multi-beat commands use INCR with SEQ beats as REQ-022.
REQ-033 Macro undefined: every beat issued as HBURST=SINGLE, HTRANS=NONSEQ, with one HTRANS=IDLE cycle between beats; beat count, addressing and data ordering unchanged.

Structure
REQ-034 Shared package holds HTRANS encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), HBURST encodings (SINGLE=000, INCR=001), HSIZE byte constant, state enum.
REQ-035 Single module; no sub-module needed.

Verification
REQ-036 Single write addr=0x3 len=0 wdata=0xA5, HREADY=1 -> NONSEQ/SINGLE at 0x3, HWDATA=0xA5 next cycle, done after 2 transfer cycles, err=0.
REQ-037 Read burst addr=0xE len=3, slave returns 0x10..0x13 -> HADDR 0xE,0xF,0x0,0x1, NONSEQ then 3 SEQ, four rdata_valid pulses in order, one done.
REQ-038 Write burst len=1 with HREADY=0 for 2 cycles on beat 0 data phase -> HADDR/HTRANS of beat 1 and HWDATA held stable until HREADY=1.
REQ-039 Read burst len=3, slave errors on beat 1 -> HTRANS=IDLE in ERR1 cycle, no beat 2/3 issued, err=1, done=1, one rdata_valid only.
REQ-040 HRESETn=0 asserted during beat 2 of 4-beat write -> all outputs at reset values next edge, no done.
REQ-041 Without AHBM_BURST_EN, len=2 read -> three NONSEQ/SINGLE beats separated by IDLE cycles.
